// File: rtl/hazard_stall_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_if
//   Bundle between the ID stage and the hazard/stall unit.
//   master : the ID stage. It drives the IF/ID contents, valid and flush, and
//            receives the hold/bubble controls, the EX tag and the stall
//            counter.
//   slave  : the hazard_stall_unit itself.
//   Signals:
//     ifid_reg[63:0]   IF/ID register; the instruction is in [31:0]
//     ifid_valid       IF/ID holds a real instruction
//     flush            kill the instruction in ID (taken branch/jump)
//     pc_hold          hold the PC this cycle
//     ifid_hold        hold IF/ID this cycle
//     idex_bubble      load a NOP into ID/EX this cycle
//     ex_dest[4:0]     destination tag in EX (0 = none)
//     ex_is_load       the EX tag belongs to a load
//     stall_cnt        saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [63:0]      ifid_reg;
    logic             ifid_valid;
    logic             flush;
    logic             pc_hold;
    logic             ifid_hold;
    logic             idex_bubble;
    logic [4:0]       ex_dest;
    logic             ex_is_load;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_reg, ifid_valid, flush,
        input  pc_hold, ifid_hold, idex_bubble, ex_dest, ex_is_load, stall_cnt
    );

    modport slave (
        input  ifid_reg, ifid_valid, flush,
        output pc_hold, ifid_hold, idex_bubble, ex_dest, ex_is_load, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//   Producer-side partner of the forwarding unit. It follows the destination
//   register of each in-flight instruction through an EX/MEM/WR tag pipeline
//   and stalls ID when forwarding cannot help:
//     - load-use: an ID source is produced by the load currently in EX
//     - beq/bne compare in ID: a source is produced by anything in EX, or by
//       a load in MEM
//   Ports:
//     clk    pipeline clock
//     rst    asynchronous, active-high reset
//     hz_if  slave side of hazard_stall_unit_if (IF/ID in, controls out)
//   CNT_W sets the width of the saturating stall counter (minimum 2).
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave hz_if
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_SRA    = 6'b000011;
    localparam logic [5:0] FN_JR     = 6'b001000;

    typedef struct packed {
        logic       vld;
        logic [4:0] dest;
        logic       is_load;
    } tag_t;

    // ---------------------------------------------------------------------
    // ID decode
    // ---------------------------------------------------------------------
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    assign instr = hz_if.ifid_reg[31:0];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];

    logic [4:0] id_dest;
    logic       id_load;
    logic       use_rs;
    logic       use_rt;
    logic       id_branch;

    always_comb begin
        id_dest   = 5'd0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        id_branch = 1'b0;
        case (op)
            OP_RTYPE: begin
                id_dest = (funct == FN_JR) ? 5'd0 : rd;
                // Shift-by-immediate: rs field is unused by the datapath.
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
                    use_rt = 1'b1;
                end else begin
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
            end
            OP_JAL: id_dest = 5'd31;
            OP_J: ;
            OP_SW, OP_SB, OP_SH: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                use_rs    = 1'b1;
                use_rt    = 1'b1;
                id_branch = 1'b1;
            end
            // Single-operand branches: compare rs against zero, no dest.
            OP_REGIMM, OP_BLEZ, OP_BGTZ: use_rs = 1'b1;
            default: begin
                id_dest = rt;
                use_rs  = 1'b1;
            end
        endcase
    end

    assign id_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);

    // Register 0 never creates a dependency; mapping an unused operand to 0
    // lets a single compare cover both cases.
    logic [4:0] src_rs;
    logic [4:0] src_rt;

    assign src_rs = use_rs ? rs : 5'd0;
    assign src_rt = use_rt ? rt : 5'd0;

    // ---------------------------------------------------------------------
    // Tag pipeline
    // ---------------------------------------------------------------------
    tag_t ex_q;
    tag_t mem_q;
    tag_t wr_q;
    tag_t ex_d;

    function automatic logic src_hit(input tag_t t, input logic [4:0] a,
                                     input logic [4:0] b);
        return t.vld && (((a != 5'd0) && (a == t.dest)) ||
                         ((b != 5'd0) && (b == t.dest)));
    endfunction

    logic id_live;
    logic stall_l1;
    logic stall_b1;
    logic stall_b2;
    logic stall;

    // A flushed ID instruction is dead, so it can neither stall nor enter EX.
    assign id_live  = hz_if.ifid_valid && !hz_if.flush;
    assign stall_l1 = ex_q.is_load && src_hit(ex_q, src_rs, src_rt);
    assign stall_b1 = id_branch && src_hit(ex_q, src_rs, src_rt);
    assign stall_b2 = id_branch && mem_q.is_load && src_hit(mem_q, src_rs, src_rt);
    assign stall    = id_live && (stall_l1 || stall_b1 || stall_b2);

    always_comb begin
        ex_d = '0;
        // Stalled ID stays in IF/ID, so a bubble goes to EX instead.
        if (id_live && !stall && (id_dest != 5'd0)) begin
            ex_d.vld     = 1'b1;
            ex_d.dest    = id_dest;
            ex_d.is_load = id_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wr_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wr_q  <= mem_q;
        end
    end

    // The WR tag mirrors the datapath but no hazard here depends on it.
    logic wr_unused;
    assign wr_unused = ^wr_q;

    // ---------------------------------------------------------------------
    // Saturating stall counter
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign hz_if.pc_hold     = stall;
    assign hz_if.ifid_hold   = stall;
    assign hz_if.idex_bubble = stall;
    assign hz_if.ex_dest     = ex_q.vld ? ex_q.dest : 5'd0;
    assign hz_if.ex_is_load  = ex_q.vld && ex_q.is_load;
    assign hz_if.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ireg = '0;
    logic        ival = 1'b0;
    logic        iflush = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(16)) bus ();
    hazard_stall_unit_if #(.CNT_W(2))  bus2 ();

    assign bus.ifid_reg    = ireg;
    assign bus.ifid_valid  = ival;
    assign bus.flush       = iflush;
    assign bus2.ifid_reg   = ireg;
    assign bus2.ifid_valid = ival;
    assign bus2.flush      = iflush;

    hazard_stall_unit #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .hz_if(bus));
    hazard_stall_unit #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hz_if(bus2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                          input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    localparam int FN_ADD = 32, FN_SUB = 34, FN_SLL = 0, FN_JR = 8;

    // ---------------- reference model ----------------
    // History of the last three issued instructions: register written
    // (0 = nothing) and whether it came from a load. Index 0 = EX.
    int hd[3];
    bit hl[3];
    int mcnt;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hd[i] = 0;
            hl[i] = 1'b0;
        end
        mcnt = 0;
    endtask

    // Architectural reading of one instruction.
    task automatic decode(input logic [31:0] ins, output int dst, output bit ld,
                          output int s0, output int s1, output bit br2);
        int op, fn, rs, rt, rd;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        dst = 0; s0 = 0; s1 = 0; br2 = 0;
        ld = (op == 35) || (op == 32) || (op == 36);
        if (op == 0) begin
            dst = (fn == 8) ? 0 : rd;
            if (fn == 0 || fn == 2 || fn == 3) s1 = rt;
            else begin s0 = rs; s1 = rt; end
        end else if (op == 3) dst = 31;
        else if (op == 2) ;
        else if (op == 43 || op == 40 || op == 41) begin s0 = rs; s1 = rt; end
        else if (op == 4 || op == 5) begin s0 = rs; s1 = rt; br2 = 1; end
        else if (op == 1 || op == 6 || op == 7) s0 = rs;
        else begin dst = rt; s0 = rs; end
    endtask

    function automatic bit reads(input int s0, input int s1, input int r);
        return (r != 0) && (s0 == r || s1 == r);
    endfunction

    // One pipeline cycle: present ID contents, check at negedge, advance model.
    task automatic cyc(input logic [31:0] ins, input bit v, input bit f, output bit st);
        int dst, s0, s1, c2;
        bit ld, br2;
        ireg = {$urandom, ins};
        ival = v;
        iflush = f;
        @(negedge clk);
        decode(ins, dst, ld, s0, s1, br2);
        st = v && !f && ((hl[0] && reads(s0, s1, hd[0])) ||
                         (br2 && reads(s0, s1, hd[0])) ||
                         (br2 && hl[1] && reads(s0, s1, hd[1])));
        c2 = (mcnt > 3) ? 3 : mcnt;
        chk("pc_hold",     32'(bus.pc_hold),     32'(st));
        chk("ifid_hold",   32'(bus.ifid_hold),   32'(st));
        chk("idex_bubble", 32'(bus.idex_bubble), 32'(st));
        chk("ex_dest",     32'(bus.ex_dest),     32'(hd[0]));
        chk("ex_is_load",  32'(bus.ex_is_load),  32'(hd[0] != 0 && hl[0]));
        chk("stall_cnt",   32'(bus.stall_cnt),   32'(mcnt));
        chk("stall_cnt2",  32'(bus2.stall_cnt),  32'(c2));
        chk("pc_hold2",    32'(bus2.pc_hold),    32'(st));
        if (st && mcnt < 65535) mcnt++;
        hd[2] = hd[1]; hl[2] = hl[1];
        hd[1] = hd[0]; hl[1] = hl[0];
        hd[0] = (st || f || !v) ? 0 : dst;
        hl[0] = (st || f || !v) ? 1'b0 : ld;
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, holding it in ID while it stalls.
    task automatic issue(input logic [31:0] ins, output int n);
        bit st;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(ins, 1'b1, 1'b0, st);
            if (!st) return;
            n++;
        end
        chk("stall_bound", 32'(n), 32'd2);
    endtask

    task automatic drain();
        bit st;
        for (int k = 0; k < 3; k++) cyc(32'h0, 1'b0, 1'b0, st);
    endtask

    function automatic logic [31:0] rnd_ins();
        int rs, rt, rd;
        rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
        case ($urandom_range(0, 13))
            0:  return rtype(rs, rt, rd, 0, FN_ADD);
            1:  return rtype(rs, rt, rd, 2, FN_SLL);
            2:  return rtype(rs, 0, 0, 0, FN_JR);
            3:  return itype(6'b100011, rs, rt, 4);
            4:  return itype(6'b100000, rs, rt, 1);
            5:  return itype(6'b100100, rs, rt, 2);
            6:  return itype(6'b101011, rs, rt, 8);
            7:  return itype(6'b000100, rs, rt, 3);
            8:  return itype(6'b000101, rs, rt, 3);
            9:  return itype(6'b000001, rs, rt, 3);
            10: return itype(6'b000110, rs, rt, 3);
            11: return {6'b000010, 26'(rs * 7 + rt)};
            12: return {6'b000011, 26'(rd * 5 + 1)};
            default: return itype(6'b001000, rs, rt, 9);
        endcase
    endfunction

    initial begin
        int n;
        bit st;
        logic [31:0] cur;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_pc_hold", 32'(bus.pc_hold), 32'd0);
        chk("rst_ex_dest", 32'(bus.ex_dest), 32'd0);
        chk("rst_cnt",     32'(bus.stall_cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // lw $8 -> add $9,$8,$10 : one-cycle load-use
        issue(itype(6'b100011, 1, 8, 0), n);
        issue(rtype(8, 10, 9, 0, FN_ADD), n);
        chk("lu_len", 32'(n), 32'd1);
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        drain();

        // lw $8 -> beq $8,$2 : two cycles
        issue(itype(6'b100011, 1, 8, 0), n);
        issue(itype(6'b000100, 8, 2, 4), n);
        chk("lwbr_len", 32'(n), 32'd2);
        chk("lwbr_cnt", 32'(bus.stall_cnt), 32'd3);
        drain();

        // add $8 -> beq $2,$8 : one cycle; add $8 -> sub : none
        issue(rtype(1, 2, 8, 0, FN_ADD), n);
        issue(itype(6'b000100, 2, 8, 4), n);
        chk("alubr_len", 32'(n), 32'd1);
        drain();
        issue(rtype(1, 2, 8, 0, FN_ADD), n);
        issue(rtype(8, 3, 9, 0, FN_SUB), n);
        chk("alualu_len", 32'(n), 32'd0);
        drain();

        // Register 0 and shift operand selection
        issue(itype(6'b100011, 1, 0, 0), n);
        chk("lw0_ex_dest", 32'(bus.ex_dest), 32'd0);
        issue(rtype(0, 0, 9, 0, FN_ADD), n);
        chk("r0_len", 32'(n), 32'd0);
        drain();
        issue(itype(6'b100011, 1, 8, 0), n);
        issue(rtype(0, 8, 9, 2, FN_SLL), n);
        chk("sll_rt_len", 32'(n), 32'd1);
        drain();
        issue(itype(6'b100011, 1, 8, 0), n);
        issue(rtype(8, 7, 9, 2, FN_SLL), n);
        chk("sll_rs_len", 32'(n), 32'd0);
        drain();

        // flush beats a load-use stall; bubble enters EX
        issue(itype(6'b100011, 1, 8, 0), n);
        cyc(rtype(8, 10, 9, 0, FN_ADD), 1'b1, 1'b1, st);
        chk("flush_stall", 32'(st), 32'd0);
        chk("flush_ex_dest", 32'(bus.ex_dest), 32'd0);
        drain();

        // Asynchronous reset in the middle of a two-cycle branch stall
        issue(itype(6'b100011, 1, 8, 0), n);
        cyc(itype(6'b000100, 8, 2, 4), 1'b1, 1'b0, st);
        chk("pre_rst_hold", 32'(bus.pc_hold), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_hold",   32'(bus.pc_hold),     32'd0);
        chk("mid_rst_bubble", 32'(bus.idex_bubble), 32'd0);
        chk("mid_rst_cnt",    32'(bus.stall_cnt),   32'd0);
        chk("mid_rst_cnt2",   32'(bus2.stall_cnt),  32'd0);
        chk("mid_rst_exld",   32'(bus.ex_is_load),  32'd0);
        ival = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Five load-use pairs: narrow counter saturates at 3
        for (int p = 0; p < 5; p++) begin
            issue(itype(6'b100011, 1, 8, 0), n);
            issue(rtype(8, 10, 9, 0, FN_ADD), n);
        end
        chk("sat_cnt2", 32'(bus2.stall_cnt), 32'd3);
        chk("sat_cnt",  32'(bus.stall_cnt),  32'd5);
        drain();

        // Random traffic; stalled instructions are held in ID
        st = 1'b0;
        cur = rnd_ins();
        for (int k = 0; k < 600; k++) begin
            bit v, f;
            if (!st) cur = rnd_ins();
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 9) == 0);
            cyc(cur, v, f, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
